// File: rtl/cmac_tx_arb.sv
// Two-source AXI-Stream arbiter feeding the CMAC tx port: round-robin packet grants,
// zero-latency pass-through, oversize-packet truncation with drain, per-source packet counters.
`timescale 1ns/1ps
module cmac_tx_arb #(
  parameter int DATA_W    = 512,
  parameter int KEEP_W    = DATA_W/8,
  parameter int MAX_BEATS = 250,
  parameter int CNT_W     = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              tx_en,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,
  input  logic              s0_axis_tuser,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,
  input  logic              s1_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              trunc_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat moves on any port only in a cycle where tvalid && tready are both
  // high; a source holds tvalid and its payload stable until that cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT_IDX = BEAT_W'(MAX_BEATS - 1);

  state_t             r_state;
  state_t             w_next_state;
  // Owner of the current/last packet; also the round-robin pointer (1 => s0 favoured next).
  logic               r_owner;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]   r_pkt_cnt0;
  logic [CNT_W-1:0]   r_pkt_cnt1;
  logic               r_trunc_err;

  logic               w_src_valid;
  logic [DATA_W-1:0]  w_src_data;
  logic [KEEP_W-1:0]  w_src_keep;
  logic               w_src_last;
  logic               w_src_user;
  logic               w_in_gnt;
  logic               w_accept;
  logic               w_at_limit;
  logic               w_trunc_hit;
  logic               w_out_last_acc;

  assign w_src_valid = r_owner ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_src_data  = r_owner ? s1_axis_tdata  : s0_axis_tdata;
  assign w_src_keep  = r_owner ? s1_axis_tkeep  : s0_axis_tkeep;
  assign w_src_last  = r_owner ? s1_axis_tlast  : s0_axis_tlast;
  assign w_src_user  = r_owner ? s1_axis_tuser  : s0_axis_tuser;

  assign w_in_gnt       = (r_state == GNT0) || (r_state == GNT1);
  assign w_accept       = w_in_gnt && w_src_valid && m_axis_tready;
  assign w_at_limit     = (r_beat_cnt == LAST_BEAT_IDX);
  // A source tlast landing exactly on the limit beat is a normal end, not a truncation.
  assign w_trunc_hit    = w_at_limit && !w_src_last;
  assign w_out_last_acc = w_accept && m_axis_tlast;

  always_comb begin
    w_next_state   = r_state;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    grant          = 2'b00;
    case (r_state)
      IDLE: begin
        if (tx_en && (s0_axis_tvalid || s1_axis_tvalid)) begin
          if (s0_axis_tvalid && (!s1_axis_tvalid || r_owner)) w_next_state = GNT0;
          else w_next_state = GNT1;
        end
      end
      GNT0, GNT1: begin
        m_axis_tvalid = w_src_valid;
        m_axis_tdata  = w_src_data;
        m_axis_tkeep  = w_src_keep;
        m_axis_tlast  = w_src_last | w_trunc_hit;
        m_axis_tuser  = w_src_user | w_trunc_hit;
        grant         = r_owner ? 2'b10 : 2'b01;
        if (r_owner) s1_axis_tready = m_axis_tready;
        else s0_axis_tready = m_axis_tready;
        if (w_src_valid && m_axis_tready) begin
          if (w_src_last) w_next_state = IDLE;
          else if (w_at_limit) w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        // Swallow the rest of the oversize packet; nothing reaches the MAC.
        grant = r_owner ? 2'b10 : 2'b01;
        if (r_owner) s1_axis_tready = 1'b1;
        else s0_axis_tready = 1'b1;
        if (w_src_valid && w_src_last) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_owner <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_next_state == GNT0) r_owner <= 1'b0;
      else if (r_state == IDLE && w_next_state == GNT1) r_owner <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat_cnt <= '0;
    end else if (w_next_state == IDLE) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_cnt0  <= '0;
      r_pkt_cnt1  <= '0;
      r_trunc_err <= 1'b0;
    end else begin
      if (w_out_last_acc && !r_owner) r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
      if (w_out_last_acc && r_owner)  r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
      if (w_accept && w_trunc_hit)    r_trunc_err <= 1'b1;
    end
  end

  assign pkt_cnt0  = r_pkt_cnt0;
  assign pkt_cnt1  = r_pkt_cnt1;
  assign trunc_err = r_trunc_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cmac_tx_arb.sv
// Bench for cmac_tx_arb: arbitration vector table, directed multi-cycle sequences,
// and randomized traffic scored against per-source expected beat queues.
`timescale 1ns/1ps
module tb_cmac_tx_arb;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int MB = 4;
  localparam int CW = 4;
  localparam int BW = DW + KW + 2;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic                  tx_en;
  logic [1:0]            s_tvalid, s_tlast, s_tuser;
  logic [1:0][DW-1:0]    s_tdata;
  logic [1:0][KW-1:0]    s_tkeep;
  logic                  s0_tready, s1_tready;
  logic [1:0]            s_tready;
  logic                  m_tvalid, m_tready, m_tlast, m_tuser, trunc_err;
  logic [DW-1:0]         m_tdata;
  logic [KW-1:0]         m_tkeep;
  logic [1:0]            grant, dbg_state;
  logic [CW-1:0]         pkt_cnt0, pkt_cnt1;

  assign s_tready = {s1_tready, s0_tready};

  cmac_tx_arb #(.DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(MB), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .tx_en(tx_en),
    .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tready(s0_tready), .s0_axis_tdata(s_tdata[0]),
    .s0_axis_tkeep(s_tkeep[0]), .s0_axis_tlast(s_tlast[0]), .s0_axis_tuser(s_tuser[0]),
    .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tready(s1_tready), .s1_axis_tdata(s_tdata[1]),
    .s1_axis_tkeep(s_tkeep[1]), .s1_axis_tlast(s_tlast[1]), .s1_axis_tuser(s_tuser[1]),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_err(trunc_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q0[$];
  logic [BW-1:0] exp_q1[$];
  int  exp_cnt[2];
  bit  exp_trunc;
  int  start_src_q[$];
  time start_t_q[$];
  time last_acc_t[2];
  int  rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the test
  int  en_mode  = 0;   // 0: driven by the test, 1: random
  bit  mon_en   = 1'b0;

  typedef struct packed {
    logic       tx_en;
    logic       v0;
    logic       v1;
    logic [1:0] exp_gnt;
  } vec_t;
  vec_t vecs[10];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    exp_trunc  = 1'b0;
    start_src_q.delete();
    start_t_q.delete();
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    tx_en    = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    tick(1);
    clear_model();
  endtask

  // ---------------- driver ----------------
  // Expected output of a packet follows from its length alone: the first MB beats pass,
  // the MB-th beat of a longer packet is closed with tlast/tuser, the rest vanish.
  task automatic send_pkt(input int src, input int len, input int gap_max);
    logic [DW-1:0] dq[$];
    logic [KW-1:0] kq[$];
    logic          uq[$];
    bit            acc;
    int            waited;
    for (int i = 0; i < len; i++) begin
      dq.push_back($urandom);
      kq.push_back(KW'($urandom));
      uq.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < len && i < MB; i++) begin
      logic lst, usr;
      lst = (i == len - 1) || (i == MB - 1);
      usr = uq[i] | ((i == MB - 1) && (len > MB));
      if (src == 0) exp_q0.push_back({dq[i], kq[i], lst, usr});
      else exp_q1.push_back({dq[i], kq[i], lst, usr});
    end
    exp_cnt[src]++;
    if (len > MB) exp_trunc = 1'b1;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        s_tvalid[src] = 1'b0;
        tick(1);
      end
      s_tvalid[src] = 1'b1;
      s_tdata[src]  = dq[i];
      s_tkeep[src]  = kq[i];
      s_tlast[src]  = (i == len - 1);
      s_tuser[src]  = uq[i];
      acc    = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge aclk);
        acc = s_tready[src];
        if (acc && i == len - 1) last_acc_t[src] = $time;
        tick(1);
        waited++;
        if (!acc && waited > 500) begin
          total++;
          bad++;
          $display("FAIL handshake_timeout: src%0d beat %0d never accepted, expected acceptance", src, i);
          s_tvalid[src] = 1'b0;
          return;
        end
      end
    end
    s_tvalid[src] = 1'b0;
  endtask

  // ---------------- background processes ----------------
  task automatic mon_loop();
    bit in_pkt = 1'b0;
    bit prev_last = 1'b0;
    int src;
    logic [BW-1:0] e;
    forever begin
      @(negedge aclk);
      if (!aresetn || !mon_en) begin
        in_pkt    = 1'b0;
        prev_last = 1'b0;
      end else begin
        src = grant[1] ? 1 : 0;
        if (prev_last) chk("bubble_after_tlast", m_tvalid, 0);
        if (m_tvalid) begin
          chk("grant_onehot", (grant == 2'b01) || (grant == 2'b10), 1);
          chk("tready_mirror", src ? s1_tready : s0_tready, m_tready);
          chk("tready_other", src ? s0_tready : s1_tready, 0);
        end
        prev_last = 1'b0;
        if (m_tvalid && m_tready) begin
          if (!in_pkt) begin
            start_src_q.push_back(src);
            start_t_q.push_back($time);
          end
          if ((src == 0 && exp_q0.size() == 0) || (src == 1 && exp_q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL extra_beat: src%0d data %0h, expected no beat", src, m_tdata);
          end else begin
            e = (src == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
            chk("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, e);
          end
          in_pkt    = !m_tlast;
          prev_last = m_tlast;
        end
      end
    end
  endtask

  task automatic rdy_loop();
    forever begin
      @(posedge aclk);
      #1;
      if (rdy_mode == 0) m_tready = 1'b1;
      else if (rdy_mode == 1) m_tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic en_loop();
    forever begin
      @(posedge aclk);
      #1;
      if (en_mode == 1) tx_en = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic watchdog();
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt0"}, pkt_cnt0, exp_cnt[0] % (1 << CW));
    chk({tag, "_cnt1"}, pkt_cnt1, exp_cnt[1] % (1 << CW));
    chk({tag, "_trunc"}, trunc_err, exp_trunc);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int tbl_s0, tbl_s1;
    time t1;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 2'b00};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 2'b01};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 2'b10};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b01};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 2'b01};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 2'b10};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'b01};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 2'b10};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 2'b01};

    aresetn  = 1'b0;
    tx_en    = 1'b1;
    s_tvalid = 2'b11;
    s_tlast  = '0;
    s_tuser  = 2'b11;
    s_tdata  = '1;
    s_tkeep  = '1;
    m_tready = 1'b1;
    fork
      mon_loop();
      rdy_loop();
      en_loop();
      watchdog();
    join_none

    // Reset values with requesters active.
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", {m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
    chk("rst_s_tready", {s1_tready, s0_tready}, 0);
    chk("rst_cnts", {pkt_cnt1, pkt_cnt0, trunc_err}, 0);
    do_reset();

    // Arbitration table: single-beat packets, grant decided from IDLE.
    tbl_s0 = 0;
    tbl_s1 = 0;
    for (int i = 0; i < 10; i++) begin
      tx_en      = vecs[i].tx_en;
      s_tvalid   = {vecs[i].v1, vecs[i].v0};
      s_tlast    = 2'b11;
      s_tuser    = 2'b00;
      s_tkeep    = '1;
      s_tdata[0] = 32'hA000_0000 + DW'(i);
      s_tdata[1] = 32'hB000_0000 + DW'(i);
      @(negedge aclk);
      chk($sformatf("tbl%0d_idle_tvalid", i), m_tvalid, 0);
      @(negedge aclk);
      chk($sformatf("tbl%0d_grant", i), grant, vecs[i].exp_gnt);
      if (vecs[i].exp_gnt != 2'b00) begin
        chk($sformatf("tbl%0d_data", i), m_tdata, vecs[i].exp_gnt[1] ? s_tdata[1] : s_tdata[0]);
        chk($sformatf("tbl%0d_last", i), {m_tvalid, m_tlast}, 2'b11);
      end
      if (vecs[i].exp_gnt == 2'b01) tbl_s0++;
      if (vecs[i].exp_gnt == 2'b10) tbl_s1++;
      tick(1);
      s_tvalid = 2'b00;
    end
    tick(1);
    chk("tbl_cnt0", pkt_cnt0, tbl_s0);
    chk("tbl_cnt1", pkt_cnt1, tbl_s1);
    do_reset();

    mon_en = 1'b1;
    tx_en  = 1'b1;

    // Single 3-beat packet from s1.
    fork
      send_pkt(1, 3, 0);
      begin
        @(negedge aclk);
        chk("one_pkt_gnt_c0", grant, 0);
        @(negedge aclk);
        chk("one_pkt_gnt_c1", grant, 2'b10);
      end
    join
    tick(2);
    chk_counts("one_pkt");

    // Both sources back-to-back: strict alternation starting with s0.
    start_src_q.delete();
    fork
      for (int p = 0; p < 4; p++) send_pkt(0, 2, 0);
      for (int p = 0; p < 4; p++) send_pkt(1, 2, 0);
    join
    tick(2);
    chk("rr_pkts", start_src_q.size(), 8);
    for (int i = 0; i < 8 && i < start_src_q.size(); i++)
      chk($sformatf("rr_order%0d", i), start_src_q[i], i % 2);
    chk_counts("rr");

    // Output back-pressure toggling 1010 during a 4-beat s0 packet.
    rdy_mode = 2;
    fork
      send_pkt(0, 4, 0);
      for (int i = 0; i < 12; i++) begin
        m_tready = (i % 2 == 0);
        tick(1);
      end
    join
    m_tready = 1'b1;
    rdy_mode = 0;
    tick(2);
    chk_counts("bp");

    // tlast on exactly beat MB: normal packet.
    send_pkt(0, MB, 0);
    tick(2);
    chk_counts("at_limit");

    // Oversize s0 packet, s1 waiting behind it.
    fork
      send_pkt(0, MB + 2, 0);
      begin
        tick(2);
        send_pkt(1, 2, 0);
      end
    join
    tick(2);
    chk_counts("trunc");
    t1 = start_t_q[$];
    chk("trunc_next_src", start_src_q[$], 1);
    chk("trunc_next_after_drain", t1 > last_acc_t[0], 1);

    // tx_en dropped mid-packet: packet completes, nothing new is granted.
    fork
      send_pkt(0, 5, 0);
      begin
        tick(2);
        tx_en = 1'b0;
      end
    join
    fork
      send_pkt(1, 2, 0);
      begin
        repeat (8) begin
          @(negedge aclk);
          chk("txen_low_grant", grant, 0);
        end
        @(posedge aclk);
        #1;
        tx_en = 1'b1;
      end
    join
    tick(2);
    chk_counts("txen");

    // Reset asserted mid-packet.
    mon_en      = 1'b0;
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b0;
    tick(3);
    @(negedge aclk);
    chk("midrst_pre_grant", grant, 2'b01);
    aresetn = 1'b0;
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_s0_tready", s0_tready, 0);
    chk("midrst_cnts", {pkt_cnt1, pkt_cnt0, trunc_err}, 0);
    s_tvalid[0] = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_after_grant", grant, 0);
    tick(1);
    clear_model();
    mon_en = 1'b1;

    // Counter wrap: 15 packets then one more.
    for (int p = 0; p < 15; p++) send_pkt(0, 1, 0);
    tick(2);
    chk("wrap_15", pkt_cnt0, 15);
    send_pkt(0, 1, 0);
    tick(2);
    chk("wrap_0", pkt_cnt0, 0);
    chk_counts("wrap");

    // Randomized traffic from both sources with random back-pressure and tx_en.
    rdy_mode = 1;
    en_mode  = 1;
    fork
      for (int p = 0; p < 25; p++) send_pkt(0, $urandom_range(1, 7), 2);
      for (int p = 0; p < 25; p++) send_pkt(1, $urandom_range(1, 7), 2);
    join
    en_mode  = 0;
    rdy_mode = 0;
    tick(1);
    tx_en = 1'b1;
    tick(4);
    chk("rand_q0_empty", exp_q0.size(), 0);
    chk("rand_q1_empty", exp_q1.size(), 0);
    chk_counts("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmac_tx_arb.md
CMAC_TX_ARB -- requirements
Module: cmac_tx_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 512, meaning the AXIS data width in bits.
REQ-002 The block SHALL have parameter KEEP_W, default DATA_W/8 (64), meaning the tkeep width.
REQ-003 The block SHALL have parameter MAX_BEATS, default 250, meaning the maximum beats per packet (16000 B / 64 B) before truncation.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the width of each packet counter.
REQ-005 aclk  input  1  the single clock for the whole block; it is the CMAC txusrclk2 domain.
REQ-006 aresetn  input  1  asynchronous, active-low reset.
REQ-007 tx_en  input  1  link ready; new grants are allowed only while this is high.
REQ-008 s0_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/DATA_W/KEEP_W/1/1  requester 0, the ERNIC stream.
REQ-009 s1_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/DATA_W/KEEP_W/1/1  requester 1, the packet-generator stream.
REQ-010 m_axis_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/DATA_W/KEEP_W/1/1  output to the CMAC tx_axis port.
REQ-011 grant  output  2  one-hot current owner: 01 = s0, 10 = s1, 00 = none.
REQ-012 pkt_cnt0, pkt_cnt1  output  CNT_W each  count of packets forwarded per source.
REQ-013 trunc_err  output  1  sticky flag; set when a packet is truncated.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, GNT0, GNT1, DRAIN.
REQ-015 In IDLE, when tx_en=1 and exactly one sX_axis_tvalid=1, the FSM SHALL move to GNTX on the next cycle.
REQ-016 In IDLE, when tx_en=1 and both sources are valid, the FSM SHALL grant the source not granted last (round-robin); the pointer after reset SHALL favour s0.
REQ-017 In IDLE, m_axis_tvalid=0, both sX_axis_tready=0, m_axis_tdata/tkeep/tlast/tuser=0, and grant=00.
REQ-018 In GNTX the datapath SHALL pass through combinationally with zero latency.
  - m_axis_* = sX_axis_*
  - sX_axis_tready = m_axis_tready
  - the non-granted source's tready = 0
REQ-019 A beat SHALL be transferred only when tvalid && tready; an accepted tlast beat SHALL return the FSM to IDLE on the next cycle. This gives one bubble cycle between packets.
REQ-020 Deasserting tx_en mid-packet SHALL NOT interrupt the packet; it only blocks the next grant from IDLE.
REQ-021 A beat counter SHALL count accepted beats in GNTX and clear on IDLE entry.
REQ-022 On accepted beat number MAX_BEATS without source tlast, the block SHALL:
  - force m_axis_tlast=1 and m_axis_tuser=1 on that beat
  - set trunc_err
  - move to DRAIN
REQ-023 In DRAIN, the granted source's tready=1 and m_axis_tvalid=0; the block SHALL discard beats until the source's tlast is accepted, then go to IDLE.
REQ-024 If the source tlast coincides with beat MAX_BEATS, the packet SHALL pass normally: no truncation, no DRAIN.
REQ-025 pkt_cntX SHALL increment by 1 on every m_axis tlast beat accepted from source X, truncated packets included, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 grant SHALL equal 01 in GNT0 and in DRAIN-from-s0, and 10 in GNT1 and in DRAIN-from-s1.
REQ-027 s_axis_tuser SHALL be forwarded unchanged to m_axis_tuser except in the forced case of REQ-022.

Reset
REQ-028 While aresetn=0, the block SHALL force asynchronously:
  - FSM = IDLE, round-robin pointer = favour s0
  - beat counter = 0, pkt_cnt0 = 0, pkt_cnt1 = 0, trunc_err = 0
  - all outputs to their IDLE values per REQ-017
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no completion beat; after release the FSM SHALL start in IDLE.
REQ-030 Release of aresetn SHALL take effect on the first aclk rising edge after deassertion; deassertion SHALL be synchronised externally.

Verification
REQ-031 tx_en=1, only s1 sends one 3-beat packet, m_tready=1 -> grant=10 from cycle 1; 3 m beats identical to input; pkt_cnt1=1; pkt_cnt0=0.
REQ-032 Both sources hold continuous 2-beat packets -> grants alternate s0,s1,s0,s1 with one IDLE bubble between packets; after 8 packets pkt_cnt0=4, pkt_cnt1=4.
REQ-033 m_tready toggled 1010 during a 4-beat s0 packet -> no beat lost or duplicated; s0_tready mirrors m_tready; s1_tready stays 0.
REQ-034 MAX_BEATS=4, s0 sends 6 beats -> beat 4 out with tlast=1, tuser=1; beats 5-6 consumed with m_tvalid=0; trunc_err=1; pkt_cnt0=1; next grant after s0 tlast.
REQ-035 tx_en dropped at beat 2 of 5 -> all 5 beats complete; no further grant until tx_en=1; aresetn pulsed mid-packet -> counters 0, grant=00, m_tvalid=0 immediately.
REQ-036 pkt_cnt0 preloaded by sending 2^CNT_W-1 packets (CNT_W=4: 15) plus 1 more -> pkt_cnt0 reads 0.
